// File: rtl/seq_detector_prog.sv
`default_nettype none
// ============================================================================
// Module      : seq_detector_prog
// Description : Programmable sequence detector. A run-time-loaded pattern of
//               up to MAX_LEN symbols (DATA_W bits each) is matched against a
//               qualified symbol stream. Overlapping or non-overlapping
//               detection is selectable. Matches are counted by a saturating
//               counter.
//
// Ports       : clk            rising-edge system clock
//               reset_n        asynchronous active-low reset
//               cfg_we         pattern slot write strobe (also drops history)
//               cfg_addr       pattern slot index, 0 = first symbol
//               cfg_data       pattern symbol to write
//               cfg_mask       per-slot compare mask (SEQ_DET_MASK_EN only)
//               cfg_len        active pattern length, 0 = off, clamped
//               overlap        1 = overlapping, 0 = non-overlapping
//               data           input symbol
//               data_valid     input symbol qualifier
//               clr_count      synchronous clear of match_count
//               sequence_found one-cycle registered match pulse
//               match_count    saturating match counter
//
// Build macro : SEQ_DET_MASK_EN adds cfg_mask and per-slot don't-care bits.
// Revision    : 1.0  initial release
// ============================================================================
module seq_detector_prog #(
    parameter int DATA_W  = 3,
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int ADDR_W  = $clog2(MAX_LEN)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
`ifdef SEQ_DET_MASK_EN
    input  logic [DATA_W-1:0] cfg_mask,
`endif
    input  logic [ADDR_W:0]   cfg_len,
    input  logic              overlap,
    input  logic [DATA_W-1:0] data,
    input  logic              data_valid,
    input  logic              clr_count,
    output logic              sequence_found,
    output logic [CNT_W-1:0]  match_count
);

    localparam int               c_hist_n   = MAX_LEN - 1;
    localparam logic [ADDR_W:0]  c_max_len  = (ADDR_W+1)'(MAX_LEN);
    localparam logic [ADDR_W:0]  c_len_one  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_fill_one = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_fill_max = ADDR_W'(MAX_LEN - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_max  = '1;

    logic [DATA_W-1:0] r_pat  [MAX_LEN];
    logic [DATA_W-1:0] r_hist [c_hist_n];
    logic [ADDR_W-1:0] r_fill;          // valid history symbols since last flush
    logic              r_found;
    logic [CNT_W-1:0]  r_count;

    logic [DATA_W-1:0] w_win  [MAX_LEN]; // w_win[0] is the incoming symbol
    logic [DATA_W-1:0] w_mask [MAX_LEN];
    logic [ADDR_W:0]   w_len;
    logic [ADDR_W:0]   w_j;
    logic [ADDR_W-1:0] w_idx;
    logic              w_match;

    // ------------------------------------------------------------------------
    // Compare window: current symbol followed by the history, newest first
    // ------------------------------------------------------------------------
    assign w_win[0] = data;
    generate
        for (genvar k = 1; k < MAX_LEN; k++) begin : g_win
            assign w_win[k] = r_hist[k-1];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Optional per-slot mask; without it every bit participates
    // ------------------------------------------------------------------------
`ifdef SEQ_DET_MASK_EN
    logic [DATA_W-1:0] r_mask [MAX_LEN];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < MAX_LEN; k++) begin
                r_mask[k] <= '1;
            end
        end else if (cfg_we) begin
            r_mask[cfg_addr] <= cfg_mask;
        end
    end

    generate
        for (genvar k = 0; k < MAX_LEN; k++) begin : g_mask
            assign w_mask[k] = r_mask[k];
        end
    endgenerate
`else
    generate
        for (genvar k = 0; k < MAX_LEN; k++) begin : g_mask
            assign w_mask[k] = '1;
        end
    endgenerate
`endif

    assign w_len = (cfg_len > c_max_len) ? c_max_len : cfg_len;

    // ------------------------------------------------------------------------
    // Match: pattern slot j lines up with window age L-1-j. The index is
    // computed modulo MAX_LEN, which is exact because L-1-j lies in range.
    // ------------------------------------------------------------------------
    always_comb begin
        w_j     = '0;
        w_idx   = '0;
        w_match = data_valid && (w_len != '0) &&
                  ({1'b0, r_fill} >= (w_len - c_len_one));
        for (int j = 0; j < MAX_LEN; j++) begin
            w_j = j[ADDR_W:0];
            if (w_j < w_len) begin
                w_idx = w_len[ADDR_W-1:0] - c_fill_one - w_j[ADDR_W-1:0];
                if (((w_win[w_idx] ^ r_pat[j]) & w_mask[j]) != '0) begin
                    w_match = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Pattern store, history, fill level, pulse and counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < MAX_LEN; k++) begin
                r_pat[k] <= '0;
            end
            for (int k = 0; k < c_hist_n; k++) begin
                r_hist[k] <= '0;
            end
            r_fill  <= '0;
            r_found <= 1'b0;
            r_count <= '0;
        end else begin
            if (cfg_we) begin
                r_pat[cfg_addr] <= cfg_data;
            end

            if (data_valid) begin
                r_hist[0] <= data;
                for (int k = 1; k < c_hist_n; k++) begin
                    r_hist[k] <= r_hist[k-1];
                end
            end

            // A non-overlapping match consumes its symbols; a pattern write
            // discards partial history but still keeps a same-cycle symbol.
            if (w_match && !overlap) begin
                r_fill <= '0;
            end else if (cfg_we) begin
                r_fill <= data_valid ? c_fill_one : '0;
            end else if (data_valid && (r_fill != c_fill_max)) begin
                r_fill <= r_fill + c_fill_one;
            end

            r_found <= w_match;

            if (clr_count) begin
                r_count <= '0;
            end else if (w_match && (r_count != c_cnt_max)) begin
                r_count <= r_count + c_cnt_one;
            end
        end
    end

    assign sequence_found = r_found;
    assign match_count    = r_count;

endmodule
`default_nettype wire
